// File: rtl/gated_latch_bank_if.sv
// gated_latch_bank_if: control, data and status bundle for gated_latch_bank.
interface gated_latch_bank_if #(
    parameter int WIDTH    = 8,
    parameter int CHANNELS = 4
);
    logic                      CE;
    logic [CHANNELS-1:0]       G;
    logic [CHANNELS-1:0]       CLEAR;
    logic [CHANNELS*WIDTH-1:0] D;
    logic [CHANNELS*WIDTH-1:0] Q;
    logic [CHANNELS-1:0]       QV;
    logic [CHANNELS-1:0]       UPD;
    modport master (output CE, G, CLEAR, D, input Q, QV, UPD);
    modport slave (input CE, G, CLEAR, D, output Q, QV, UPD);
endinterface

// File: rtl/gated_latch_bank.sv
// gated_latch_bank: per-channel gated hold registers with clear and a DEPTH-stage output pipeline.
// Define GATED_LATCH_BANK_UPD_EN to generate the registered per-channel change pulse on UPD.
module gated_latch_bank #(
    parameter int               WIDTH     = 8,
    parameter int               CHANNELS  = 4,
    parameter int               DEPTH     = 2,
    parameter logic [WIDTH-1:0] INIT      = '0,
    parameter logic [WIDTH-1:0] CLEAR_VAL = '0,
    parameter bit               GATE_POL  = 1'b0
) (
    input logic               CLK,
    input logic               RESETN,
    gated_latch_bank_if.slave bus
);
    if (DEPTH < 1) begin : g_bad_depth
        $error("gated_latch_bank: DEPTH must be at least 1");
    end
    for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
        logic [WIDTH-1:0] stg [DEPTH];
        logic [DEPTH-1:0] vld;
        logic [WIDTH-1:0] h_nxt;
        logic             v_nxt;
        always_comb begin
            h_nxt = bus.CLEAR[c] ? CLEAR_VAL : (bus.G[c] == GATE_POL) ? bus.D[c*WIDTH +: WIDTH] : stg[0];
            v_nxt = bus.CLEAR[c] ? 1'b0 : (bus.G[c] == GATE_POL) ? 1'b1 : vld[0];
        end
        always_ff @(posedge CLK) begin
            if (!RESETN) begin
                for (int k = 0; k < DEPTH; k++) stg[k] <= INIT;
                vld <= '0;
            end else if (bus.CE) begin
                stg[0] <= h_nxt;
                vld[0] <= v_nxt;
                for (int k = 1; k < DEPTH; k++) begin
                    stg[k] <= stg[k-1];
                    vld[k] <= vld[k-1];
                end
            end
        end
        assign bus.Q[c*WIDTH +: WIDTH] = stg[DEPTH-1];
        assign bus.QV[c]               = vld[DEPTH-1];
`ifdef GATED_LATCH_BANK_UPD_EN
        // Compare the value Q is about to take against its current value.
        logic [WIDTH-1:0] q_nxt;
        logic             upd;
        if (DEPTH == 1) begin : g_d1
            assign q_nxt = h_nxt;
        end else begin : g_dn
            assign q_nxt = stg[DEPTH-2];
        end
        always_ff @(posedge CLK) begin
            if (!RESETN) upd <= 1'b0;
            else if (bus.CE) upd <= q_nxt != stg[DEPTH-1];
        end
        assign bus.UPD[c] = upd;
`else
        assign bus.UPD[c] = 1'b0;
`endif
    end
endmodule
